// File: rtl/elevator_pkg.sv
// Shared types and default sizing for the single-car elevator dispatcher.
package elevator_pkg;

  localparam int DEF_N       = 20;
  localparam int DEF_FLOOR_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    DOOR
  } state_t;

  typedef enum logic {
    UP,
    DOWN
  } dir_t;

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter shared by floor travel and door dwell; done while the count is zero.
module dwell_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         count,
  output logic         done
);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (count && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/elevator_dispatcher.sv
// SCAN-policy request scheduler and motion/door sequencer for one elevator car.
module elevator_dispatcher
  import elevator_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int FLOOR_W     = DEF_FLOOR_W,
  parameter int MOVE_CYCLES = 8,
  parameter int DOOR_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       up_request,
  input  logic [N-1:0]       down_request,
  input  logic [FLOOR_W-1:0] in_request,
  input  logic               in_valid,
  input  logic               open_in,
  input  logic               close_in,
  output logic [FLOOR_W-1:0] Floor,
  output logic               up,
  output logic               down,
  output logic               door_open,
  output logic [N-1:0]       pend_up,
  output logic [N-1:0]       pend_down,
  output logic [N-1:0]       pend_in
);

  localparam int MAXC = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TW   = $clog2(MAXC);
  localparam logic [TW-1:0] MOVE_LOAD  = TW'(MOVE_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD  = TW'(DOOR_CYCLES - 1);
  localparam logic [N-1:0]  TOP_BIT    = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]  BOTTOM_BIT = {{(N-1){1'b0}}, 1'b1};

  state_t state, state_n;
  dir_t   dir, dir_n;
  logic [FLOOR_W-1:0] floor_n, next_floor, stop_floor;
  logic [N-1:0] pend_all, stop_onehot, clr_up, clr_down, set_up, set_down, set_in;
  logic ahead_cur, behind_cur, ahead_next, at_top, at_bottom, end_next;
  logic hall_here_match, hall_here_opp, hall_next_match, hall_next_opp;
  logic door_entry, clear_both, tmr_load, tmr_done;
  logic [TW-1:0] tmr_value;

  // Bits strictly beyond floor f in direction d (thermometer mask).
  function automatic logic [N-1:0] beyond_mask(input logic [FLOOR_W-1:0] f, input dir_t d);
    beyond_mask = '0;
    for (int i = 0; i < N; i++) begin
      beyond_mask[i] = (d == UP) ? (i > int'(f)) : (i < int'(f));
    end
  endfunction

  function automatic dir_t opposite(input dir_t d);
    return (d == UP) ? DOWN : UP;
  endfunction

  assign pend_all   = pend_up | pend_down | pend_in;
  assign ahead_cur  = |(pend_all & beyond_mask(Floor, dir));
  assign behind_cur = |(pend_all & beyond_mask(Floor, opposite(dir)));
  assign at_top     = (Floor == FLOOR_W'(N - 1));
  assign at_bottom  = (Floor == '0);

  always_comb begin
    next_floor = Floor;
    if (dir == UP && !at_top) begin
      next_floor = Floor + 1'b1;
    end else if (dir == DOWN && !at_bottom) begin
      next_floor = Floor - 1'b1;
    end
  end

  assign ahead_next      = |(pend_all & beyond_mask(next_floor, dir));
  assign end_next        = (next_floor == FLOOR_W'(N - 1)) || (next_floor == '0);
  assign hall_here_match = (dir == UP) ? pend_up[Floor]        : pend_down[Floor];
  assign hall_here_opp   = (dir == UP) ? pend_down[Floor]      : pend_up[Floor];
  assign hall_next_match = (dir == UP) ? pend_up[next_floor]   : pend_down[next_floor];
  assign hall_next_opp   = (dir == UP) ? pend_down[next_floor] : pend_up[next_floor];

  // A lone opposite-direction call here waits while work remains ahead, so IDLE never reopens forever.
  always_comb begin
    state_n    = state;
    dir_n      = dir;
    floor_n    = Floor;
    stop_floor = Floor;
    door_entry = 1'b0;
    clear_both = 1'b0;
    tmr_load   = 1'b0;
    tmr_value  = MOVE_LOAD;
    unique case (state)
      IDLE: begin
        if (pend_in[Floor] || hall_here_match || (hall_here_opp && !ahead_cur)) begin
          state_n    = DOOR;
          door_entry = 1'b1;
          clear_both = !ahead_cur;
          tmr_load   = 1'b1;
          tmr_value  = DOOR_LOAD;
        end else if (ahead_cur) begin
          state_n  = MOVE;
          tmr_load = 1'b1;
        end else if (behind_cur) begin
          state_n  = MOVE;
          dir_n    = opposite(dir);
          tmr_load = 1'b1;
        end
      end
      MOVE: begin
        if (tmr_done) begin
          floor_n    = next_floor;
          stop_floor = next_floor;
          tmr_load   = 1'b1;
          if (pend_in[next_floor] || hall_next_match || !ahead_next || end_next) begin
            state_n    = DOOR;
            door_entry = 1'b1;
            clear_both = !ahead_next;
            tmr_value  = DOOR_LOAD;
            if (!ahead_next && hall_next_opp) begin
              dir_n = opposite(dir);
            end
          end
        end
      end
      DOOR: begin
        if (open_in) begin
          tmr_load  = 1'b1;
          tmr_value = DOOR_LOAD;
        end else if (tmr_done) begin
          state_n = IDLE;
        end else if (close_in) begin
          tmr_load  = 1'b1;
          tmr_value = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign stop_onehot = door_entry ? (BOTTOM_BIT << stop_floor) : '0;
  assign clr_up      = (clear_both || dir == UP)   ? stop_onehot : '0;
  assign clr_down    = (clear_both || dir == DOWN) ? stop_onehot : '0;
  assign set_up      = up_request & ~TOP_BIT;
  assign set_down    = down_request & ~BOTTOM_BIT;
  assign set_in      = (in_valid && int'(in_request) < N) ? (BOTTOM_BIT << in_request) : '0;

  dwell_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .value (tmr_value),
    .count (state != IDLE),
    .done  (tmr_done)
  );

  // NOTE: pending vectors are reset like any other control state: a stale call after reset would move the car.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      dir       <= UP;
      Floor     <= '0;
      pend_up   <= '0;
      pend_down <= '0;
      pend_in   <= '0;
    end else begin
      state     <= state_n;
      dir       <= dir_n;
      Floor     <= floor_n;
      pend_up   <= (pend_up & ~clr_up) | set_up;
      pend_down <= (pend_down & ~clr_down) | set_down;
      pend_in   <= (pend_in & ~stop_onehot) | set_in;
    end
  end

  assign up        = (state == MOVE) && (dir == UP);
  assign down      = (state == MOVE) && (dir == DOWN);
  assign door_open = (state == DOOR);

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Directed scenarios plus random traffic against a procedural SCAN model of the car.
module tb_elevator_dispatcher;

  localparam int N  = 20;
  localparam int FW = 5;
  localparam int MC = 8;
  localparam int DC = 16;
  localparam int P_IDLE = 0, P_MOVE = 1, P_DOOR = 2;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] up_request, down_request;
  logic [FW-1:0] in_request;
  logic in_valid, open_in, close_in;
  logic [FW-1:0] Floor;
  logic up, down, door_open;
  logic [N-1:0] pend_up, pend_down, pend_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: position, +1/-1 heading, phase, edges left in the current phase.
  int m_floor, m_dir, m_phase, m_left;
  bit m_pu[N], m_pd[N], m_pi[N];

  elevator_dispatcher #(.N(N), .FLOOR_W(FW), .MOVE_CYCLES(MC), .DOOR_CYCLES(DC)) dut (
    .clk          (clk),
    .reset        (reset),
    .up_request   (up_request),
    .down_request (down_request),
    .in_request   (in_request),
    .in_valid     (in_valid),
    .open_in      (open_in),
    .close_in     (close_in),
    .Floor        (Floor),
    .up           (up),
    .down         (down),
    .door_open    (door_open),
    .pend_up      (pend_up),
    .pend_down    (pend_down),
    .pend_in      (pend_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit any_beyond(input int f, input int d);
    for (int g = 0; g < N; g++) begin
      if ((d > 0 ? g > f : g < f) && (m_pu[g] || m_pd[g] || m_pi[g])) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit hall_call(input int f, input int d);
    return (d > 0) ? m_pu[f] : m_pd[f];
  endfunction

  function automatic logic [N-1:0] pack(input bit a[N]);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = a[i];
    return v;
  endfunction

  task automatic model_reset();
    m_floor = 0;
    m_dir   = 1;
    m_phase = P_IDLE;
    m_left  = 0;
    for (int i = 0; i < N; i++) begin
      m_pu[i] = 1'b0;
      m_pd[i] = 1'b0;
      m_pi[i] = 1'b0;
    end
  endtask

  // Advance the model by one clock edge given the inputs presented for that edge.
  task automatic model_step(input logic [N-1:0] ur, input logic [N-1:0] dr, input logic [FW-1:0] ir,
                            input logic iv, input logic op, input logic cl);
    int stop_at = -1;
    int travel  = m_dir;
    bit clear_both = 1'b0;
    bit ahead;
    int nf;
    case (m_phase)
      P_IDLE: begin
        ahead = any_beyond(m_floor, m_dir);
        if (m_pi[m_floor] || hall_call(m_floor, m_dir) || (hall_call(m_floor, -m_dir) && !ahead)) begin
          m_phase = P_DOOR; m_left = DC; stop_at = m_floor; clear_both = !ahead;
        end else if (ahead) begin
          m_phase = P_MOVE; m_left = MC;
        end else if (any_beyond(m_floor, -m_dir)) begin
          m_dir = -m_dir; m_phase = P_MOVE; m_left = MC;
        end
      end
      P_MOVE: begin
        m_left--;
        if (m_left == 0) begin
          nf = m_floor + m_dir;
          if (nf < 0) nf = 0;
          if (nf > N - 1) nf = N - 1;
          m_floor = nf;
          ahead = any_beyond(nf, m_dir);
          if (m_pi[nf] || hall_call(nf, m_dir) || !ahead || nf == 0 || nf == N - 1) begin
            m_phase = P_DOOR; m_left = DC; stop_at = nf; clear_both = !ahead;
            if (!ahead && hall_call(nf, -m_dir)) m_dir = -m_dir;
          end else begin
            m_left = MC;
          end
        end
      end
      default: begin
        if (op) begin
          m_left = DC;
        end else begin
          m_left--;
          if (m_left == 0) m_phase = P_IDLE;
          else if (cl) m_left = 1;
        end
      end
    endcase
    if (stop_at >= 0) begin
      m_pi[stop_at] = 1'b0;
      if (clear_both || travel > 0) m_pu[stop_at] = 1'b0;
      if (clear_both || travel < 0) m_pd[stop_at] = 1'b0;
    end
    for (int f = 0; f < N; f++) begin
      if (ur[f] && f != N - 1) m_pu[f] = 1'b1;
      if (dr[f] && f != 0) m_pd[f] = 1'b1;
    end
    if (iv && int'(ir) < N) m_pi[ir] = 1'b1;
  endtask

  task automatic compare_all();
    check("floor", Floor, m_floor);
    check("up", up, (m_phase == P_MOVE && m_dir > 0));
    check("down", down, (m_phase == P_MOVE && m_dir < 0));
    check("door_open", door_open, (m_phase == P_DOOR));
    check("pend_up", pend_up, pack(m_pu));
    check("pend_down", pend_down, pack(m_pd));
    check("pend_in", pend_in, pack(m_pi));
  endtask

  task automatic cycle(input logic [N-1:0] ur, input logic [N-1:0] dr, input logic [FW-1:0] ir,
                       input logic iv, input logic op, input logic cl);
    @(negedge clk);
    up_request = ur; down_request = dr; in_request = ir;
    in_valid = iv; open_in = op; close_in = cl;
    model_step(ur, dr, ir, iv, op, cl);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle('0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_floor"}, Floor, 0);
    check({tag, "_up"}, up, 0);
    check({tag, "_down"}, down, 0);
    check({tag, "_door"}, door_open, 0);
    check({tag, "_pend"}, {pend_up, pend_down, pend_in}, 0);
  endtask

  initial begin
    int hold;
    logic [N-1:0] ur, dr;
    logic [FW-1:0] ir;
    logic iv, op, cl;
    int r;

    reset = 1'b0;
    up_request = '0; down_request = '0; in_request = '0;
    in_valid = 1'b0; open_in = 1'b0; close_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b1;

    // Quiet car stays parked at the ground floor.
    idle(100);
    check_reset_values("idle100");

    // Cabin call to floor 5 from floor 0.
    cycle('0, '0, 5'd5, 1'b1, 1'b0, 1'b0);
    idle(1);
    check("trip_up", up, 1);
    idle(40);
    check("trip_floor5", Floor, 5);
    check("trip_door", door_open, 1);
    idle(15);
    check("trip_door_dwell", door_open, 1);
    idle(1);
    check("trip_door_closed", door_open, 0);
    check("trip_pend_in", pend_in, 0);

    // From floor 2 up to 9 with hall calls picked up mid-trip; returns to serve the down call at 6.
    cycle('0, '0, 5'd2, 1'b1, 1'b0, 1'b0);
    idle(60);
    check("at_floor2", Floor, 2);
    cycle('0, '0, 5'd9, 1'b1, 1'b0, 1'b0);
    idle(10);
    cycle(N'(1) << 4, '0, '0, 1'b0, 1'b0, 1'b0);
    cycle('0, N'(1) << 6, '0, 1'b0, 1'b0, 1'b0);
    idle(200);
    check("sweep_end_floor6", Floor, 6);

    // Door held open at floor 3, then shortened by close.
    cycle('0, '0, 5'd3, 1'b1, 1'b0, 1'b0);
    idle(25);
    check("hold_arrive", door_open, 1);
    repeat (40) cycle('0, '0, '0, 1'b0, 1'b1, 1'b0);
    idle(10);
    check("hold_still_open", door_open, 1);
    cycle('0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("close_press_cycle", door_open, 1);
    idle(1);
    check("close_done", door_open, 0);

    // Out-of-range requests are dropped; the top floor never steps further.
    cycle(N'(1) << (N - 1), N'(1), 5'd25, 1'b1, 1'b0, 1'b0);
    check("ignored_pend", {pend_up, pend_down, pend_in}, 0);
    cycle('0, '0, 5'd19, 1'b1, 1'b0, 1'b0);
    idle(150);
    check("top_floor", Floor, N - 1);
    cycle(N'(1) << (N - 1), '0, '0, 1'b0, 1'b0, 1'b0);
    idle(50);
    check("top_saturate", Floor, N - 1);
    check("top_no_up", up, 0);

    // Reset while travelling down past floor 7 with calls still pending.
    cycle('0, '0, 5'd0, 1'b1, 1'b0, 1'b0);
    cycle(N'(1) << 12, '0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 400 && m_floor != 7; i++) idle(1);
    check("reach_floor7", Floor, 7);
    idle(3);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_values("reset_hold");
    reset = 1'b1;

    // Random traffic against the model.
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      ur = '0; dr = '0; iv = 1'b0;
      ir = FW'($urandom_range(0, 31));
      r = $urandom_range(0, 99);
      if (r < 4) ur[$urandom_range(0, N - 1)] = 1'b1;
      else if (r < 8) dr[$urandom_range(0, N - 1)] = 1'b1;
      else if (r < 13) iv = 1'b1;
      if (hold > 0) begin
        op = 1'b1;
        hold--;
      end else begin
        op = 1'b0;
        if ($urandom_range(0, 199) == 0) hold = $urandom_range(1, 20);
      end
      cl = ($urandom_range(0, 49) == 0);
      cycle(ur, dr, ir, iv, op, cl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/elevator_dispatcher.md
# elevator_dispatcher

Single-car request scheduler and motion/door sequencer for the elevator design. It latches hall and cabin requests into pending vectors, runs a SCAN (collective) policy to choose direction and stops, times floor-to-floor travel and door dwell, and drives the car floor, direction and door outputs. It is the block that sequences the car datapath: request selection, state control and wait counting live here under one clock.

## Interface
- N, 20, number of floors (2..32)
- FLOOR_W, 5, floor index width (ceil log2 N)
- MOVE_CYCLES, 8, clock cycles per floor of travel (>=2)
- DOOR_CYCLES, 16, door dwell cycles (>=2)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- up_request  in  N  hall up-call pulses, bit f = floor f; bit N-1 ignored
- down_request  in  N  hall down-call pulses; bit 0 ignored
- in_request  in  FLOOR_W  cabin destination floor number
- in_valid  in  1  qualifies in_request for one cycle; values >= N ignored
- open_in  in  1  door-open button (cabin)
- close_in  in  1  door-close button (cabin)
- Floor  out  FLOOR_W  current car floor
- up  out  1  car moving up
- down  out  1  car moving down
- door_open  out  1  door open
- pend_up, pend_down, pend_in  out  N each  latched pending requests

## Operation
- Pending registers: bit set on request pulse; cleared on service (below). Same-cycle set and clear of one bit: set wins.
- dir register (UP/DOWN), reset UP; "ahead" = any pending bit strictly above (UP) or below (DOWN) Floor.
- States: IDLE, MOVE, DOOR.
- IDLE: any pending bit at Floor -> DOOR. Else if request ahead in dir -> MOVE keeping dir. Else if request in opposite direction -> flip dir, MOVE. Else stay IDLE.
- MOVE: up = (dir==UP), down = (dir==DOWN). Move timer counts MOVE_CYCLES; on terminal cycle Floor steps ±1. At new floor stop (-> DOOR) if pend_in[f], or hall call in dir at f, or no request ahead (then dir flips if opposite hall call exists at f). Else restart timer, stay MOVE.
- Floor saturates: never steps below 0 or above N-1; reaching an end floor always stops.
- DOOR entry clears pend_in[Floor] and the dir-matching hall bit at Floor; if nothing ahead, both hall bits at Floor cleared.
- DOOR: door_open=1, dwell timer counts DOOR_CYCLES. open_in restarts timer (held open while asserted). close_in with open_in low forces expiry next cycle; open_in wins if both. Expiry -> IDLE.
- Requests during MOVE/DOOR latch normally; a call at Floor during DOOR stays pending and reopens the door via IDLE.

## Timing
- Reset (async assert, sync release): Floor=0, up=down=door_open=0, all pending=0, IDLE, dir=UP, timers 0.
- Request pulse at edge k -> pending bit visible after edge k; IDLE acts on it at edge k+1 (up/down or door_open high after k+1).
- MOVE: Floor changes exactly MOVE_CYCLES edges after entering MOVE or after previous step; up/down stay high continuously through non-stop floors.
- Stop: state DOOR and door_open high the edge Floor updates; up/down low same edge.
- DOOR lasts DOOR_CYCLES edges unextended; close_in shortens to 1 cycle after press.
- Reset mid-MOVE/DOOR: immediate return to reset values; pending requests lost.

## Structure
- elevator_pkg: state enum (IDLE, MOVE, DOOR), dir enum (UP, DOWN), default N/FLOOR_W constants.
- One sub-module dwell_timer (load, count, done; width from max(MOVE_CYCLES, DOOR_CYCLES)); instantiate twice (move, door) or once shared, since MOVE and DOOR are exclusive.
- Ahead/behind detection combinational via masked OR of pending vectors against Floor thermometer.

## Test plan
- Reset then idle: no requests for 100 cycles -> Floor=0, up=down=door_open=0.
- in_request=5 pulse at floor 0 -> up high, Floor reaches 5 after 5*MOVE_CYCLES+1 cycles, door_open for DOOR_CYCLES, then IDLE, pend_in all 0.
- Car moving up from 2 to 9; up_request[4] and down_request[6] mid-trip -> stops at 4, passes 6, stops 9, then reverses, stops 6 going down.
- Door at floor 3: open_in held 40 cycles -> door_open stays high 40+DOOR_CYCLES; close_in pulse -> door_open low next cycle.
- up_request[N-1], down_request[0], in_request=25 -> ignored, pending stay 0; car at N-1 never increments Floor.
- reset asserted mid-MOVE at floor 7 -> outputs immediately reset values, Floor=0, pending cleared.
